// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - state encoding of the fetch FSM
//   - address/instruction widths and the per-instruction PC increment
//   - align_pc: clears bit 0 so every PC is halfword aligned
package fetch_unit_pkg;

  localparam int unsigned AddrWidth  = 16;
  localparam int unsigned InstrWidth = 16;

  // Instructions are 16 bits wide, so sequential fetch advances by two bytes.
  localparam logic [AddrWidth-1:0] InstrInc  = 16'd2;
  localparam logic [AddrWidth-1:0] AlignMask = {{(AddrWidth-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  function automatic logic [AddrWidth-1:0] align_pc(input logic [AddrWidth-1:0] addr);
    return addr & AlignMask;
  endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential PC adder: pc_next = pc + InstrInc, modulo 2^AddrWidth (no carry out).
//   pc       in   current program counter
//   pc_next  out  address of the following instruction
module pc_incr
  import fetch_unit_pkg::*;
(
  input  logic [AddrWidth-1:0] pc,
  output logic [AddrWidth-1:0] pc_next
);

  always_comb begin
    pc_next = pc + InstrInc;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one request at a time to instruction memory,
// holds the returned word for decode, and follows redirects from the back end.
//   clk, rst_n                   clock, synchronous active-low reset
//   imem_req/imem_addr           fetch request and its byte address (the PC)
//   imem_ack/imem_rdata          request accepted, data valid in the same cycle
//   instr_valid/instr/instr_pc   held instruction presented to decode
//   instr_ready                  decode accepts the held instruction
//   redirect/redirect_pc         control-flow change and its target
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [AddrWidth-1:0] RESET_PC = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [AddrWidth-1:0]  imem_addr,
  input  logic                  imem_ack,
  input  logic [InstrWidth-1:0] imem_rdata,
  output logic                  instr_valid,
  output logic [InstrWidth-1:0] instr,
  output logic [AddrWidth-1:0]  instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [AddrWidth-1:0]  redirect_pc
);

  state_e                  state_q, state_d;
  logic [AddrWidth-1:0]    pc_q, pc_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [AddrWidth-1:0]    pend_pc_q, pend_pc_d;
  logic [InstrWidth-1:0]   instr_q, instr_d;
  logic [AddrWidth-1:0]    instr_pc_q, instr_pc_d;
  logic [AddrWidth-1:0]    pc_plus;
  logic [AddrWidth-1:0]    redirect_tgt;

  pc_incr u_pc_incr (
    .pc      (pc_q),
    .pc_next (pc_plus)
  );

  assign redirect_tgt = align_pc(redirect_pc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= align_pc(RESET_PC);
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) pc_d = redirect_tgt;
      end

      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // Data fetched down a stale path is dropped; refetch from the newest target.
          if (redirect) begin
            pc_d         = redirect_tgt;
            pend_valid_d = 1'b0;
          end else if (pend_valid_q) begin
            pc_d         = pend_pc_q;
            pend_valid_d = 1'b0;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_plus;
            state_d    = S_OUT;
          end
        end else if (redirect) begin
          // imem_addr must stay stable until ack, so park the target.
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_tgt;
        end
      end

      S_OUT: begin
        instr_valid = 1'b1;
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
        end else if (instr_ready) begin
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign instr_pc  = instr_pc_q;

endmodule
